apb_dac_multi: RTL and testbench
================================

Name: apb_dac_multi

Overview:
- Parametrised multi-channel successor to the single-channel APB DAC.
- APB slave with an address decoder, a configurable wait-state counter, and error response.
- Per-channel holding and active code registers, double-buffered through an LDAC strobe.
- Real-valued analog outputs for mixed-signal testbenches, sitting on the same APB bus as the ADC and DAC models.

Parameters:
- NCH, 4, number of DAC channels (1..16)
- DW, 16, DAC resolution in bits (1..32)
- AW, 8, PADDR width
- WAIT_STATES, 1, PREADY-low cycles inserted in every access phase (0..15)
- VREF, 1.0 (real), full-scale output voltage

Ports:
- PCLK  in  1  bus clock; all state updates on posedge
- PRESET  in  1  asynchronous reset, active-low
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  AW  byte address
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error, valid only when PREADY=1
- code_out  out  NCH*DW  current output code per channel; channel i is at [i*DW +: DW]
- vout  out  real[NCH]  analog output per channel

Behaviour:
- Reset (PRESET=0, async) clears the following; all are held at these values while reset is low:
  - holding[i], active[i], code_out = 0
  - CTRL = 0
  - wait counter = 0
  - PRDATA = 0, PREADY = 0, PSLVERR = 0
  - vout[i] = 0.0
- A reset mid-transfer aborts it with no register write.
- Register map (word aligned):
  - 0x00 CTRL RW: bit0 EN, bit1 AUTO
  - 0x04 LDAC WO: bitmask, self-clearing; reads as 0
  - 0x08 STATUS RO: [NCH-1:0] pending = (holding != active); [16+NCH-1:16] busy
  - 0x0C SLEW RW: only with the optional feature
  - 0x10+4*i DATA_i RW, i < NCH: holding code, zero-extended on read
- Wait states:
  - wcnt increments each cycle PSEL&PENABLE&!PREADY; clears when PSEL=0 or PENABLE=0, or after PREADY.
  - PREADY = PSEL & PENABLE & (wcnt == WAIT_STATES), combinational from the registered wcnt.
  - Back-to-back transfers restart wcnt at 0.
  - WAIT_STATES=0 gives a zero-wait access phase.
- Commit: writes take effect at the posedge where PREADY=1; PRDATA is valid in that same cycle.
- Errors: PSLVERR=1 together with PREADY, with no state change, for:
  - PADDR[1:0] != 0
  - an unmapped address, or a DATA index >= NCH
  - a write to STATUS
  - a read of LDAC is not an error
- DATA_i write: holding[i] <= PWDATA[DW-1:0]; upper bits ignored. If AUTO=1, active[i] is also loaded at the same edge.
- LDAC write: active[i] <= holding[i] for each set bit i < NCH; bits >= NCH are ignored.
- code_out[i] follows active[i] one cycle after the commit edge.
- vout[i] = EN ? VREF * code_out[i] / 2.0**DW : 0.0. It updates combinationally on any change of code_out or EN.
- Full-scale code (2**DW - 1) gives VREF*(1 - 2**-DW); there is no wrap.
- PSEL without PENABLE (setup phase) causes no action. PREADY stays 0 outside access phases.

Optional Feature:
- Macro: APB_DAC_SLEW_EN.
- Defined:
  - SLEW register (0x0C, [DW-1:0], reset 0) is present.
  - Each cycle, code_out[i] moves toward active[i] by min(SLEW, |difference|).
  - SLEW=0 means immediate update.
  - busy[i] = (code_out[i] != active[i]).
  - Retargeting mid-ramp continues from the present code_out. No overshoot.
- Undefined:
  - 0x0C is unmapped and returns PSLVERR.
  - busy bits read 0.
  - code_out[i] = active[i] one cycle after commit.

Test Plan:
- Reset, then read 0x08 with WAIT_STATES=1 -> PREADY low 1 cycle then high; PRDATA=0, PSLVERR=0; all vout=0.0.
- Write CTRL=0x3 (EN, AUTO), then DATA_2=0x8000 (DW=16) -> code_out ch2=0x8000 next cycle; vout[2]=0.5; other channels 0.0.
- CTRL=0x1; write DATA_0=0x4000 and DATA_1=0xFFFF -> STATUS=0x3, vout unchanged. Write LDAC=0x1 -> vout[0]=0.25, STATUS=0x2.
- Write to 0x50 (i=16 >= NCH), write to 0x06, and write to STATUS -> each gets PSLVERR=1 with PREADY=1; a subsequent register readback is unchanged.
- Assert PRESET low during a DATA_3 write's wait cycle -> PREADY=0 immediately; DATA_3 reads 0 after reset.
- With APB_DAC_SLEW_EN: SLEW=0x100, AUTO=1, DATA_0 0 -> 0x0300 -> code_out ch0 goes 0x100, 0x200, 0x300 over 3 cycles; busy[0] is high for those cycles. Without the macro, SLEW access -> PSLVERR.

Source files
------------

// File: rtl/apb_dac_multi.sv
// Multi-channel APB DAC: double-buffered holding/active codes, LDAC strobe, wait states, real outputs.
// Optional output slew limiting is built when APB_DAC_SLEW_EN is defined.
module apb_dac_lane #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold_we,
    input  logic          auto_load,
    input  logic          ldac,
    input  logic [DW-1:0] wdata,
`ifdef APB_DAC_SLEW_EN
    input  logic [DW-1:0] slew,
`endif
    output logic [DW-1:0] holding,
    output logic [DW-1:0] active,
    output logic [DW-1:0] code
);
`ifdef APB_DAC_SLEW_EN
    logic [DW-1:0] gap;
    assign gap = (code < active) ? active - code : code - active;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holding <= '0;
            active  <= '0;
            code    <= '0;
        end else begin
            if (hold_we) holding <= wdata;
            if (hold_we && auto_load) active <= wdata;
            else if (ldac)            active <= holding;
`ifdef APB_DAC_SLEW_EN
            // Step never exceeds the remaining gap, so the ramp lands exactly on target.
            if (slew == '0 || gap <= slew) code <= active;
            else if (code < active)        code <= code + slew;
            else                           code <= code - slew;
`else
            code <= active;
`endif
        end
    end
endmodule

module apb_dac_multi #(
    parameter int  NCH         = 4,
    parameter int  DW          = 16,
    parameter int  AW          = 8,
    parameter int  WAIT_STATES = 1,
    parameter real VREF        = 1.0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [AW-1:0]     PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NCH*DW-1:0] code_out,
    output real               vout [NCH]
);
    logic [3:0]                wcnt;
    logic [1:0]                ctrl;
    logic [NCH-1:0][DW-1:0]    hold, act, code;
    logic [NCH-1:0]            pending, busy;
    logic                      access, err, commit_wr;
    logic                      sel_ctrl, sel_ldac, sel_stat, sel_slew, sel_data;
    int                        widx;
    logic [31:0]               rdata;
    logic                      unused_bits;

`ifdef APB_DAC_SLEW_EN
    logic [DW-1:0] slew;
    assign sel_slew = (widx == 3);
`else
    assign sel_slew = 1'b0;
`endif

    assign unused_bits = ^PWDATA;
    assign access    = PSEL & PENABLE;
    assign PREADY    = PRESET & access & (wcnt == 4'(WAIT_STATES));
    assign widx      = int'(PADDR[AW-1:2]);
    assign sel_ctrl  = (widx == 0);
    assign sel_ldac  = (widx == 1);
    assign sel_stat  = (widx == 2);
    assign sel_data  = (widx >= 4) && (widx < 4 + NCH);
    assign err       = (PADDR[1:0] != 2'b00)
                     | ~(sel_ctrl | sel_ldac | sel_stat | sel_slew | sel_data)
                     | (sel_stat & PWRITE);
    assign commit_wr = PREADY & ~err & PWRITE;
    assign PSLVERR   = PREADY & err;
    assign PRDATA    = (PREADY & ~err & ~PWRITE) ? rdata : 32'h0;
    assign code_out  = code;

    // wcnt restarts whenever the access phase ends so back-to-back transfers each wait fully.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            wcnt <= '0;
            ctrl <= '0;
`ifdef APB_DAC_SLEW_EN
            slew <= '0;
`endif
        end else begin
            if (!access || PREADY) wcnt <= '0;
            else                   wcnt <= wcnt + 4'd1;
            if (commit_wr && sel_ctrl) ctrl <= PWDATA[1:0];
`ifdef APB_DAC_SLEW_EN
            if (commit_wr && sel_slew) slew <= PWDATA[DW-1:0];
`endif
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        apb_dac_lane #(.DW(DW)) u_lane (
            .clk       (PCLK),
            .rst_n     (PRESET),
            .hold_we   (commit_wr && sel_data && (widx == 4 + i)),
            .auto_load (ctrl[1]),
            .ldac      (commit_wr && sel_ldac && PWDATA[i]),
            .wdata     (PWDATA[DW-1:0]),
`ifdef APB_DAC_SLEW_EN
            .slew      (slew),
`endif
            .holding   (hold[i]),
            .active    (act[i]),
            .code      (code[i])
        );
        assign pending[i] = (hold[i] != act[i]);
`ifdef APB_DAC_SLEW_EN
        assign busy[i] = (code[i] != act[i]);
`else
        assign busy[i] = 1'b0;
`endif
    end

    always_comb begin
        rdata = '0;
        if (sel_ctrl) begin
            rdata[1:0] = ctrl;
        end else if (sel_stat) begin
            rdata[NCH-1:0]     = pending;
            rdata[16 +: NCH]   = busy;
`ifdef APB_DAC_SLEW_EN
        end else if (sel_slew) begin
            rdata[DW-1:0] = slew;
`endif
        end else if (sel_data) begin
            for (int i = 0; i < NCH; i++)
                if (widx == 4 + i) rdata[DW-1:0] = hold[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++)
            vout[i] = ctrl[0] ? VREF * real'(code[i]) / (2.0 ** DW) : 0.0;
    end
endmodule

// File: tb/tb_apb_dac_multi.sv
// Randomized scoreboard bench for apb_dac_multi against a register-level reference model.
module tb_apb_dac_multi;
    localparam int  NCH = 4, DW = 16, AW = 8, WS = 1;
    localparam real VREF = 1.0;

    logic PCLK = 0, PRESET = 0, PSEL = 0, PENABLE = 0, PWRITE = 0;
    logic [AW-1:0]     PADDR = '0;
    logic [31:0]       PWDATA = '0;
    logic [31:0]       PRDATA;
    logic              PREADY, PSLVERR;
    logic [NCH*DW-1:0] code_out;
    real               vout [NCH];

    apb_dac_multi #(.NCH(NCH), .DW(DW), .AW(AW), .WAIT_STATES(WS), .VREF(VREF)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .code_out(code_out), .vout(vout)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0, errors = 0;

    typedef struct { logic [31:0] rd; bit er; string nm; } resp_t;
    resp_t sb[$];
    resp_t mon_r;

    // Reference model state
    logic [DW-1:0] hold_m [NCH], act_m [NCH], code_m [NCH];
    logic [1:0]    ctrl_m;
    logic [DW-1:0] slew_m;

    function automatic void reset_model();
        for (int i = 0; i < NCH; i++) begin hold_m[i] = 0; act_m[i] = 0; code_m[i] = 0; end
        ctrl_m = 0; slew_m = 0;
    endfunction

    function automatic logic [DW-1:0] step(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
`ifdef APB_DAC_SLEW_EN
        longint diff = longint'(tgt) - longint'(cur);
        if (slew_m == 0 || (diff <= longint'(slew_m) && -diff <= longint'(slew_m))) return tgt;
        return (diff > 0) ? DW'(longint'(cur) + longint'(slew_m)) : DW'(longint'(cur) - longint'(slew_m));
`else
        return tgt;
`endif
    endfunction

    always @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) for (int i = 0; i < NCH; i++) code_m[i] = 0;
        else         for (int i = 0; i < NCH; i++) code_m[i] = step(code_m[i], act_m[i]);
    end

    // Expected response; applies the register effect only when commit is set.
    function automatic void model(input bit wr, input int a, input logic [31:0] d, input bit commit,
                                  output logic [31:0] rd, output bit er);
        rd = '0; er = 0;
        if (a % 4 != 0) er = 1;
        else if (a == 0) begin
            if (!wr) rd = 32'(ctrl_m); else if (commit) ctrl_m = d[1:0];
        end else if (a == 4) begin
            if (wr && commit) for (int i = 0; i < NCH; i++) if (d[i]) act_m[i] = hold_m[i];
        end else if (a == 8) begin
            if (wr) er = 1;
            else for (int i = 0; i < NCH; i++) begin
                rd[i] = (hold_m[i] != act_m[i]);
`ifdef APB_DAC_SLEW_EN
                rd[16+i] = (code_m[i] != act_m[i]);
`endif
            end
        end else if (a == 12) begin
`ifdef APB_DAC_SLEW_EN
            if (!wr) rd = 32'(slew_m); else if (commit) slew_m = d[DW-1:0];
`else
            er = 1;
`endif
        end else if (a >= 16 && a < 16 + 4 * NCH) begin
            int i = (a - 16) / 4;
            if (!wr) rd = 32'(hold_m[i]);
            else if (commit) begin
                hold_m[i] = d[DW-1:0];
                if (ctrl_m[1]) act_m[i] = d[DW-1:0];
            end
        end else er = 1;
    endfunction

    task automatic apb(input bit wr, input int a, input logic [31:0] d, input string nm);
        logic [31:0] rd; bit er; int n; bit ok;
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = a[AW-1:0]; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1; n = 0;
        #1;
        while (!PREADY && n < 20) begin @(posedge PCLK); #2; n++; end
        ok = PREADY;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s timeout: PREADY=%0b after %0d cycles, required 1", nm, PREADY, n);
        end else begin
            model(wr, a, d, 0, rd, er);
            sb.push_back('{rd, er, nm});
        end
        @(posedge PCLK); #1;
        if (ok && !er) model(wr, a, d, 1, rd, er);
        PSEL = 0; PENABLE = 0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a transfer.
    int wc = 0;
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (PREADY) begin
                checks++;
                if (wc != WS) begin
                    errors++;
                    $display("FAIL wait_states got %0d required %0d", wc, WS);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready got PRDATA=%h with no pending transfer", PRDATA);
                end else begin
                    mon_r = sb.pop_front();
                    if (PRDATA !== mon_r.rd || PSLVERR !== mon_r.er) begin
                        errors++;
                        $display("FAIL %s got rdata=%h err=%0b required rdata=%h err=%0b",
                                 mon_r.nm, PRDATA, PSLVERR, mon_r.rd, mon_r.er);
                    end
                end
                wc = 0;
            end else wc++;
        end else begin
            wc = 0;
            if (PREADY !== 1'b0) begin
                checks++; errors++;
                $display("FAIL pready_idle got %b required 0", PREADY);
            end
        end
    end

    task automatic check_real(input string nm, input real got, input real want);
        checks++;
        if (got - want > 1e-9 || want - got > 1e-9) begin
            errors++;
            $display("FAIL %s got %f required %f", nm, got, want);
        end
    endtask

    task automatic check_bits(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, got, want);
        end
    endtask

    task automatic check_out(input string nm);
        for (int i = 0; i < NCH; i++) begin
            check_bits($sformatf("%s_code%0d", nm, i), 32'(code_out[i*DW +: DW]), 32'(code_m[i]));
            check_real($sformatf("%s_vout%0d", nm, i), vout[i],
                       ctrl_m[0] ? VREF * real'(code_m[i]) / (2.0 ** DW) : 0.0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, sel;
        bit wr;
        logic [31:0] d;
        reset_model();
        repeat (2) @(posedge PCLK);
        #2;
        check_bits("rst_pready", 32'(PREADY), 0);
        check_bits("rst_pslverr", 32'(PSLVERR), 0);
        check_bits("rst_prdata", PRDATA, 0);
        check_out("rst");
        @(posedge PCLK); #1 PRESET = 1;

        apb(0, 8, 0, "status_after_reset");
        check_out("post_reset");

`ifdef APB_DAC_SLEW_EN
        apb(1, 12, 32'h100, "slew_set");
        apb(1, 0, 3, "ctrl_slew");
        apb(1, 16, 32'h300, "data0_ramp");
        @(posedge PCLK); #2; check_bits("ramp1", 32'(code_out[DW-1:0]), 32'h100);
        @(posedge PCLK); #2; check_bits("ramp2", 32'(code_out[DW-1:0]), 32'h200);
        @(posedge PCLK); #2; check_bits("ramp3", 32'(code_out[DW-1:0]), 32'h300);
        apb(1, 12, 0, "slew_clear");
        apb(1, 16, 0, "data0_back");
        apb(1, 0, 0, "ctrl_off");
        check_out("slew_done");
`else
        apb(1, 12, 5, "slew_absent_wr");
        apb(0, 12, 0, "slew_absent_rd");
`endif

        apb(1, 0, 3, "ctrl_en_auto");
        apb(1, 24, 32'h8000, "data2_write");
        @(posedge PCLK); #2;
        check_out("data2");
        check_bits("data2_code", 32'(code_out[2*DW +: DW]), 32'h8000);
        check_real("vout2_half", vout[2], 0.5);
        check_real("vout0_zero", vout[0], 0.0);

        apb(1, 0, 1, "ctrl_en");
        apb(1, 16, 32'h4000, "data0_write");
        apb(1, 20, 32'hABCD_FFFF, "data1_write");
        apb(0, 8, 0, "status_pending");
        check_real("vout0_unchanged", vout[0], 0.0);
        apb(1, 4, 32'hFFFF_FFF1, "ldac0");
        @(posedge PCLK); #2;
        check_real("vout0_quarter", vout[0], 0.25);
        check_out("ldac0");
        apb(0, 8, 0, "status_after_ldac");
        apb(0, 4, 0, "ldac_read");

        apb(1, 32'h50, 32'h1234, "err_index16");
        apb(1, 32'h06, 32'h1234, "err_misaligned");
        apb(1, 32'h08, 32'h1234, "err_status_wr");
        apb(0, 32'h11, 0, "err_misaligned_rd");
        apb(0, 0, 0, "ctrl_readback");
        apb(0, 16, 0, "data0_readback");
        apb(0, 20, 0, "data1_readback");

        for (int k = 0; k < 80; k++) begin
            sel = $urandom_range(0, 9);
            wr  = 1'($urandom_range(0, 1));
            d   = $urandom;
            case (sel)
                0:       a = 0;
                1:       a = 4;
                2:       a = 8;
                3:       a = 12;
                4:       a = $urandom_range(0, 255);
                default: a = 16 + 4 * $urandom_range(0, NCH);
            endcase
            apb(wr, a, d, $sformatf("rand%0d_a%0h", k, a));
            check_out($sformatf("rand%0d", k));
        end

        // Reset during the wait cycle of a DATA_3 write must abort it.
        apb(1, 0, 1, "ctrl_before_abort");
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'h1C; PWDATA = 32'h1234;
        @(posedge PCLK); #1;
        PENABLE = 1;
        #2 PRESET = 0;
        #1;
        reset_model();
        check_bits("abort_pready", 32'(PREADY), 0);
        check_bits("abort_prdata", PRDATA, 0);
        check_out("abort");
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0;
        @(posedge PCLK); #1 PRESET = 1;
        apb(0, 28, 0, "data3_after_abort");
        apb(0, 0, 0, "ctrl_after_abort");

        repeat (3) @(posedge PCLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
